// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and access sequencer that lets the CPU
// load/store path and a DMA/debug master share the single data-memory port.
module dm_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_wr,
  input  logic [3:0]  cpu_rd,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [1:0]  dma_wr,
  input  logic [3:0]  dma_rd,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [1:0]  dm_wr,
  output logic [3:0]  dm_rd,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_data,
  input  logic [31:0] dm_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       PORT_CPU = 1'b0;
  localparam logic       PORT_DMA = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic        last_r;
  logic        owner_r;
  logic [1:0]  cmd_wr_r;
  logic [3:0]  cmd_rd_r;
  logic [31:0] cmd_addr_r;
  logic [31:0] cmd_wdata_r;
  logic [1:0]  dm_wr_r;

  logic        grant_dma_s;
  logic [1:0]  sel_wr_s;
  logic [3:0]  sel_rd_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;

  // Round-robin pick and command mux; a write suppresses the read code.
  always_comb begin
    grant_dma_s = dma_req & (~cpu_req | (last_r == PORT_CPU));
    sel_wr_s    = 2'b00;
    sel_rd_s    = 4'b0000;
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    if (grant_dma_s) begin
      sel_wr_s    = dma_wr;
      sel_addr_s  = dma_addr;
      sel_wdata_s = dma_wdata;
      sel_rd_s    = dma_rd;
    end else begin
      sel_wr_s    = cpu_wr;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
      sel_rd_s    = cpu_rd;
    end
    if (sel_wr_s != 2'b00) begin
      sel_rd_s = 4'b0000;
    end else begin
      sel_rd_s = sel_rd_s;
    end
  end

  // Transaction FSM: grant in IDLE, hold the command on the DM port in BUSY,
  // pulse the owner's ack in DONE. The command register doubles as the DM
  // port drive and is cleared whenever BUSY is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      last_r      <= PORT_DMA;
      owner_r     <= PORT_CPU;
      cmd_wr_r    <= 2'b00;
      cmd_rd_r    <= 4'b0000;
      cmd_addr_r  <= 32'h0000_0000;
      cmd_wdata_r <= 32'h0000_0000;
      dm_wr_r     <= 2'b00;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata   <= 32'h0000_0000;
      dma_rdata   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          if (cpu_req | dma_req) begin
            owner_r     <= grant_dma_s;
            last_r      <= grant_dma_s;
            cmd_wr_r    <= sel_wr_s;
            cmd_rd_r    <= sel_rd_s;
            cmd_addr_r  <= sel_addr_s;
            cmd_wdata_r <= sel_wdata_s;
            cnt_r       <= CNT_INIT;
            dm_wr_r     <= (CNT_INIT == 2'd0) ? sel_wr_s : 2'b00;
            state_r     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_r == 2'd0) begin
            if (cmd_rd_r != 4'b0000) begin
              if (owner_r == PORT_DMA) begin
                dma_rdata <= dm_out;
              end else begin
                cpu_rdata <= dm_out;
              end
            end
            cpu_ack     <= (owner_r == PORT_CPU);
            dma_ack     <= (owner_r == PORT_DMA);
            cmd_wr_r    <= 2'b00;
            cmd_rd_r    <= 4'b0000;
            cmd_addr_r  <= 32'h0000_0000;
            cmd_wdata_r <= 32'h0000_0000;
            dm_wr_r     <= 2'b00;
            state_r     <= DONE;
          end else begin
            // Write strobe only in the last BUSY cycle: one DM write edge.
            cnt_r   <= cnt_r - 2'd1;
            dm_wr_r <= (cnt_r == 2'd1) ? cmd_wr_r : 2'b00;
          end
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          cpu_ack     <= 1'b0;
          dma_ack     <= 1'b0;
          cmd_wr_r    <= 2'b00;
          cmd_rd_r    <= 4'b0000;
          cmd_addr_r  <= 32'h0000_0000;
          cmd_wdata_r <= 32'h0000_0000;
          dm_wr_r     <= 2'b00;
          cnt_r       <= 2'd0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign dm_wr     = dm_wr_r;
  assign dm_rd     = cmd_rd_r;
  assign dm_addr   = cmd_addr_r;
  assign dm_data   = cmd_wdata_r;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with one instance at LAT=1
// and one at LAT=3, each backed by a small word-addressed memory model.
module tb_dm_arbiter;

  typedef struct {
    logic        dma;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t q1[$];
  exp_t q3[$];

  logic        rst1, rst3;
  logic        c1_req, d1_req, c1_ack, d1_ack, c1_stall;
  logic [1:0]  c1_wr, d1_wr, m1_wr;
  logic [3:0]  c1_rd, d1_rd, m1_rd;
  logic [31:0] c1_addr, c1_wdata, d1_addr, d1_wdata, c1_rdata, d1_rdata;
  logic [31:0] m1_addr, m1_data, m1_out;
  logic        c3_req, d3_req, c3_ack, d3_ack, c3_stall;
  logic [1:0]  c3_wr, d3_wr, m3_wr;
  logic [3:0]  c3_rd, d3_rd, m3_rd;
  logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata, c3_rdata, d3_rdata;
  logic [31:0] m3_addr, m3_data, m3_out;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic        ld1_en = 1'b0, ld3_en = 1'b0;
  logic [5:0]  ld1_idx, ld3_idx;
  logic [31:0] ld1_data, ld3_data;

  dm_arbiter #(.LAT(1)) u1 (
    .clk(clk), .rst(rst1),
    .cpu_req(c1_req), .cpu_wr(c1_wr), .cpu_rd(c1_rd), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_ack(c1_ack), .cpu_rdata(c1_rdata), .cpu_stall(c1_stall),
    .dma_req(d1_req), .dma_wr(d1_wr), .dma_rd(d1_rd), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
    .dma_ack(d1_ack), .dma_rdata(d1_rdata),
    .dm_wr(m1_wr), .dm_rd(m1_rd), .dm_addr(m1_addr), .dm_data(m1_data), .dm_out(m1_out)
  );

  dm_arbiter #(.LAT(3)) u3 (
    .clk(clk), .rst(rst3),
    .cpu_req(c3_req), .cpu_wr(c3_wr), .cpu_rd(c3_rd), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_ack(c3_ack), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
    .dma_req(d3_req), .dma_wr(d3_wr), .dma_rd(d3_rd), .dma_addr(d3_addr), .dma_wdata(d3_wdata),
    .dma_ack(d3_ack), .dma_rdata(d3_rdata),
    .dm_wr(m3_wr), .dm_rd(m3_rd), .dm_addr(m3_addr), .dm_data(m3_data), .dm_out(m3_out)
  );

  // Memory models: write on any nonzero DMWr, combinational read.
  always @(posedge clk) begin
    if (m1_wr != 2'b00) mem1[m1_addr[7:2]] <= m1_data;
    else if (ld1_en) mem1[ld1_idx] <= ld1_data;
    if (m3_wr != 2'b00) mem3[m3_addr[7:2]] <= m3_data;
    else if (ld3_en) mem3[ld3_idx] <= ld3_data;
  end
  assign m1_out = mem1[m1_addr[7:2]];
  assign m3_out = mem3[m3_addr[7:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload1(input logic [5:0] idx, input logic [31:0] d);
    ld1_en = 1'b1; ld1_idx = idx; ld1_data = d;
    step();
    ld1_en = 1'b0;
  endtask

  task automatic preload3(input logic [5:0] idx, input logic [31:0] d);
    ld3_en = 1'b1; ld3_idx = idx; ld3_data = d;
    step();
    ld3_en = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({c1_ack, d1_ack, c1_stall, c1_rdata, d1_rdata, m1_wr, m1_rd, m1_addr, m1_data} !== 136'h0) begin
      failures++;
      $display("FAIL reset_u1: got ack=%b/%b rdata=%h/%h dm_addr=%h want all 0", c1_ack, d1_ack, c1_rdata, d1_rdata, m1_addr);
    end
    checks++;
    if ({c3_ack, d3_ack, c3_stall, c3_rdata, d3_rdata, m3_wr, m3_rd, m3_addr, m3_data} !== 136'h0) begin
      failures++;
      $display("FAIL reset_u3: got ack=%b/%b rdata=%h/%h dm_addr=%h want all 0", c3_ack, d3_ack, c3_rdata, d3_rdata, m3_addr);
    end
    step();
    rst1 = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_cpu_read();
    exp_t e;
    preload1(6'd4, 32'hDEAD_BEEF);
    step();
    c1_req = 1'b1; c1_wr = 2'b00; c1_rd = 4'b0001; c1_addr = 32'h10; c1_wdata = 32'h0;
    q1.push_back('{1'b0, 32'hDEAD_BEEF, 2});
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      if (k == 3) c1_req = 1'b0;
      @(negedge clk);
      checks++;
      if (c1_stall !== (k <= 1)) begin
        failures++;
        $display("FAIL cpu_read_stall: cycle %0d got %b want %b", k, c1_stall, (k <= 1));
      end
      if (k == 1) begin
        checks++;
        if (m1_rd !== 4'b0001 || m1_addr !== 32'h10) begin
          failures++;
          $display("FAIL cpu_read_dm: got dm_rd=%h dm_addr=%h want 1/00000010", m1_rd, m1_addr);
        end
      end
      if (c1_ack || d1_ack) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL cpu_read_ack: cycle %0d got ack cpu=%b dma=%b want none", k, c1_ack, d1_ack);
        end else begin
          e = q1.pop_front();
          if (d1_ack !== e.dma || c1_ack !== !e.dma || k != e.cyc || c1_rdata !== e.rdata) begin
            failures++;
            $display("FAIL cpu_read_ack: got cycle %0d dma=%b rdata=%h want cycle %0d dma=%b rdata=%h", k, d1_ack, c1_rdata, e.cyc, e.dma, e.rdata);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL cpu_read_timeout: got %0d pending acks want 0", q1.size());
      q1.delete();
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [31:0] got;
    preload1(6'd5, 32'hA5A5_0001);
    rst1 = 1'b1;
    c1_req = 1'b1; c1_wr = 2'b00; c1_rd = 4'b0001; c1_addr = 32'h10;
    d1_req = 1'b1; d1_wr = 2'b00; d1_rd = 4'b0001; d1_addr = 32'h14; d1_wdata = 32'h0;
    step();
    rst1 = 1'b0;
    q1.push_back('{1'b0, 32'hDEAD_BEEF, 2});
    q1.push_back('{1'b1, 32'hA5A5_0001, 5});
    q1.push_back('{1'b0, 32'hDEAD_BEEF, 8});
    q1.push_back('{1'b1, 32'hA5A5_0001, 11});
    for (int k = 0; k < 15; k++) begin
      if (k > 0) step();
      if (k == 12) begin c1_req = 1'b0; d1_req = 1'b0; end
      @(negedge clk);
      if (c1_ack || d1_ack) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL rr_ack: cycle %0d got ack cpu=%b dma=%b want none", k, c1_ack, d1_ack);
        end else begin
          e = q1.pop_front();
          got = e.dma ? d1_rdata : c1_rdata;
          if (d1_ack !== e.dma || c1_ack !== !e.dma || k != e.cyc || got !== e.rdata) begin
            failures++;
            $display("FAIL rr_ack: got cycle %0d dma=%b rdata=%h want cycle %0d dma=%b rdata=%h", k, d1_ack, got, e.cyc, e.dma, e.rdata);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL rr_timeout: got %0d pending acks want 0", q1.size());
      q1.delete();
    end
    d1_rd = 4'b0000; d1_addr = 32'h0;
  endtask

  // Drives one LAT=1 CPU command; wr+rd conflict and no-op share this flow.
  task automatic test_cmd_rules(input logic [1:0] wr, input logic [3:0] rd, input logic [31:0] wdata, input string nm);
    exp_t e;
    preload1(6'd12, 32'h0);
    step();
    c1_req = 1'b1; c1_wr = wr; c1_rd = rd; c1_addr = 32'h30; c1_wdata = wdata;
    q1.push_back('{1'b0, 32'hDEAD_BEEF, 2});
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      if (k == 3) c1_req = 1'b0;
      @(negedge clk);
      checks++;
      if (m1_rd !== 4'b0000 || m1_wr !== ((k == 1) ? wr : 2'b00)) begin
        failures++;
        $display("FAIL %s_dm: cycle %0d got dm_wr=%b dm_rd=%h want dm_wr=%b dm_rd=0", nm, k, m1_wr, m1_rd, ((k == 1) ? wr : 2'b00));
      end
      if (c1_ack || d1_ack) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL %s_ack: cycle %0d got ack cpu=%b dma=%b want none", nm, k, c1_ack, d1_ack);
        end else begin
          e = q1.pop_front();
          if (d1_ack !== e.dma || c1_ack !== !e.dma || k != e.cyc || c1_rdata !== e.rdata) begin
            failures++;
            $display("FAIL %s_ack: got cycle %0d rdata=%h want cycle %0d rdata=%h", nm, k, c1_rdata, e.cyc, e.rdata);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0 || mem1[12] !== ((wr != 2'b00) ? wdata : 32'h0)) begin
      failures++;
      $display("FAIL %s_end: got pending=%0d mem=%h want 0 and %h", nm, q1.size(), mem1[12], ((wr != 2'b00) ? wdata : 32'h0));
      q1.delete();
    end
  endtask

  task automatic test_lat3_read_write();
    exp_t e;
    logic [31:0] got;
    preload3(6'd2, 32'hCAFE_F00D);
    preload3(6'd8, 32'h0);
    step();
    c3_req = 1'b1; c3_wr = 2'b00; c3_rd = 4'b0001; c3_addr = 32'h08; c3_wdata = 32'h0;
    q3.push_back('{1'b0, 32'hCAFE_F00D, 4});
    q3.push_back('{1'b1, 32'h0, 10});
    for (int k = 0; k < 14; k++) begin
      if (k > 0) step();
      if (k == 5) c3_req = 1'b0;
      if (k == 6) begin
        d3_req = 1'b1; d3_wr = 2'b01; d3_rd = 4'b0000; d3_addr = 32'h20; d3_wdata = 32'h1234_5678;
      end
      if (k == 11) d3_req = 1'b0;
      @(negedge clk);
      checks++;
      if (m3_rd !== ((k >= 1 && k <= 3) ? 4'b0001 : 4'b0000) || m3_wr !== ((k == 9) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL lat3_dm: cycle %0d got dm_rd=%h dm_wr=%b", k, m3_rd, m3_wr);
      end
      if (k <= 4) begin
        checks++;
        if (c3_stall !== (k <= 3)) begin
          failures++;
          $display("FAIL lat3_stall: cycle %0d got %b want %b", k, c3_stall, (k <= 3));
        end
      end
      if (c3_ack || d3_ack) begin
        checks++;
        if (q3.size() == 0) begin
          failures++;
          $display("FAIL lat3_ack: cycle %0d got ack cpu=%b dma=%b want none", k, c3_ack, d3_ack);
        end else begin
          e = q3.pop_front();
          got = e.dma ? d3_rdata : c3_rdata;
          if (d3_ack !== e.dma || c3_ack !== !e.dma || k != e.cyc || got !== e.rdata) begin
            failures++;
            $display("FAIL lat3_ack: got cycle %0d dma=%b rdata=%h want cycle %0d dma=%b rdata=%h", k, d3_ack, got, e.cyc, e.dma, e.rdata);
          end
        end
      end
    end
    checks++;
    if (q3.size() != 0 || mem3[8] !== 32'h1234_5678 || c3_rdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL lat3_end: got pending=%0d mem=%h cpu_rdata=%h want 0/12345678/cafef00d", q3.size(), mem3[8], c3_rdata);
      q3.delete();
    end
    d3_wr = 2'b00; d3_addr = 32'h0; d3_wdata = 32'h0;
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    preload3(6'd9, 32'h0);
    step();
    c3_req = 1'b1; c3_wr = 2'b01; c3_rd = 4'b0000; c3_addr = 32'h24; c3_wdata = 32'h0BAD_F00D;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) step();
      if (k == 2) rst3 = 1'b1;
      if (k == 3) begin rst3 = 1'b0; c3_req = 1'b0; end
      if (k == 4) begin c3_req = 1'b1; q3.push_back('{1'b0, 32'h0, 8}); end
      if (k == 9) c3_req = 1'b0;
      @(negedge clk);
      if (k == 3) begin
        checks++;
        if ({c3_ack, d3_ack, c3_stall, c3_rdata, d3_rdata, m3_wr, m3_rd, m3_addr, m3_data} !== 136'h0) begin
          failures++;
          $display("FAIL midrst_outputs: got ack=%b rdata=%h/%h dm_wr=%b dm_addr=%h want all 0", c3_ack, c3_rdata, d3_rdata, m3_wr, m3_addr);
        end
      end
      if (k == 7) begin
        checks++;
        if (mem3[9] !== 32'h0) begin
          failures++;
          $display("FAIL midrst_nowrite: got mem=%h want 00000000", mem3[9]);
        end
      end
      if (c3_ack || d3_ack) begin
        checks++;
        if (q3.size() == 0) begin
          failures++;
          $display("FAIL midrst_ack: cycle %0d got ack cpu=%b dma=%b want none", k, c3_ack, d3_ack);
        end else begin
          e = q3.pop_front();
          if (d3_ack !== e.dma || c3_ack !== !e.dma || k != e.cyc || c3_rdata !== e.rdata) begin
            failures++;
            $display("FAIL midrst_ack: got cycle %0d rdata=%h want cycle %0d rdata=%h", k, c3_rdata, e.cyc, e.rdata);
          end
        end
      end
    end
    checks++;
    if (q3.size() != 0 || mem3[9] !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL midrst_end: got pending=%0d mem=%h want 0/0badf00d", q3.size(), mem3[9]);
      q3.delete();
    end
  endtask

  initial begin
    {c1_req, c1_wr, c1_rd, c1_addr, c1_wdata, d1_req, d1_wr, d1_rd, d1_addr, d1_wdata} = '0;
    {c3_req, c3_wr, c3_rd, c3_addr, c3_wdata, d3_req, d3_wr, d3_rd, d3_addr, d3_wdata} = '0;
    ld1_idx = 6'd0; ld1_data = 32'h0; ld3_idx = 6'd0; ld3_data = 32'h0;
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_cmd_rules(2'b00, 4'b0000, 32'h0, "noop");
    test_cmd_rules(2'b01, 4'b0001, 32'h55AA_33CC, "wr_rd_conflict");
    test_lat3_read_write();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test want finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
